gray_updown_counter: RTL and testbench



---
 rtl/gray_updown_counter.sv | 74 +++++++
 tb/tb_gray_updown_counter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// Up/down Gray-code counter with binary load, wrap or saturate mode,
// registered binary and Gray outputs and terminal-count flags.
module gray_updown_counter #(
    parameter int p_WIDTH    = 4,
    parameter bit p_SATURATE = 1'b0
) (
    input  logic               iw_clk,
    input  logic               iw_reset,
    input  logic               iw_en,
    input  logic               iw_inc,
    input  logic               iw_dec,
    input  logic               iw_load,
    input  logic [p_WIDTH-1:0] iwv_load_bin,
    output logic [p_WIDTH-1:0] owv_gray,
    output logic [p_WIDTH-1:0] owv_bin,
    output logic               ow_at_max,
    output logic               ow_at_min,
    output logic               ow_boundary
);

    localparam logic [p_WIDTH-1:0] MAX_VAL = '1;
    localparam logic [p_WIDTH-1:0] ONE     = p_WIDTH'(1);

    logic [p_WIDTH-1:0] bin_q, bin_d;
    logic [p_WIDTH-1:0] gray_q, gray_d;
    logic               boundary_q, boundary_d;
    logic               step_up, step_dn;

    assign step_up = iw_en & iw_inc & ~iw_dec;
    assign step_dn = iw_en & iw_dec & ~iw_inc;

    always_comb begin
        bin_d      = bin_q;
        boundary_d = 1'b0;
        if (iw_load) begin
            bin_d = iwv_load_bin;
        end else if (step_up) begin
            if (bin_q == MAX_VAL) begin
                boundary_d = 1'b1;
                if (!p_SATURATE) bin_d = '0;
            end else begin
                bin_d = bin_q + ONE;
            end
        end else if (step_dn) begin
            if (bin_q == '0) begin
                boundary_d = 1'b1;
                if (!p_SATURATE) bin_d = MAX_VAL;
            end else begin
                bin_d = bin_q - ONE;
            end
        end
        // Gray is derived from the next binary so both registers agree.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge iw_clk) begin
        if (iw_reset) begin
            bin_q      <= '0;
            gray_q     <= '0;
            boundary_q <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            gray_q     <= gray_d;
            boundary_q <= boundary_d;
        end
    end

    assign owv_bin     = bin_q;
    assign owv_gray    = gray_q;
    assign ow_boundary = boundary_q;
    assign ow_at_max   = (bin_q == MAX_VAL);
    assign ow_at_min   = (bin_q == '0);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: 4-bit wrap, 4-bit saturate and 1-bit wrap
// instances share stimulus and are compared against an arithmetic model.
module tb_gray_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, inc, dec, ld;
    logic [3:0] lv;

    logic [3:0] w4_gray, w4_bin, s4_gray, s4_bin;
    logic [0:0] w1_gray, w1_bin;
    logic w4_max, w4_min, w4_bnd;
    logic s4_max, s4_min, s4_bnd;
    logic w1_max, w1_min, w1_bnd;

    int total = 0;
    int bad   = 0;

    int m_w4 = 0, m_s4 = 0, m_w1 = 0;
    bit b_w4 = 0, b_s4 = 0, b_w1 = 0;

    always #5 clk = ~clk;

    gray_updown_counter #(.p_WIDTH(4), .p_SATURATE(1'b0)) u_w4 (
        .iw_clk(clk), .iw_reset(rst), .iw_en(en), .iw_inc(inc),
        .iw_dec(dec), .iw_load(ld), .iwv_load_bin(lv),
        .owv_gray(w4_gray), .owv_bin(w4_bin), .ow_at_max(w4_max),
        .ow_at_min(w4_min), .ow_boundary(w4_bnd)
    );

    gray_updown_counter #(.p_WIDTH(4), .p_SATURATE(1'b1)) u_s4 (
        .iw_clk(clk), .iw_reset(rst), .iw_en(en), .iw_inc(inc),
        .iw_dec(dec), .iw_load(ld), .iwv_load_bin(lv),
        .owv_gray(s4_gray), .owv_bin(s4_bin), .ow_at_max(s4_max),
        .ow_at_min(s4_min), .ow_boundary(s4_bnd)
    );

    gray_updown_counter #(.p_WIDTH(1), .p_SATURATE(1'b0)) u_w1 (
        .iw_clk(clk), .iw_reset(rst), .iw_en(en), .iw_inc(inc),
        .iw_dec(dec), .iw_load(ld), .iwv_load_bin(lv[0:0]),
        .owv_gray(w1_gray), .owv_bin(w1_bin), .ow_at_max(w1_max),
        .ow_at_min(w1_min), .ow_boundary(w1_bnd)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int nxt(int c, int maxv, bit sat, bit r, bit e,
                               bit i, bit d, bit l, int v, output bit bnd);
        bnd = 1'b0;
        if (r) return 0;
        if (l) return v;
        if (e && i && !d) begin
            if (c == maxv) begin
                bnd = 1'b1;
                return sat ? c : 0;
            end
            return c + 1;
        end
        if (e && d && !i) begin
            if (c == 0) begin
                bnd = 1'b1;
                return sat ? 0 : maxv;
            end
            return c - 1;
        end
        return c;
    endfunction

    function automatic int g2b(int g);
        int b = 0;
        for (int k = 0; k < 32; k++) b ^= (g >> k);
        return b;
    endfunction

    task automatic chk_inst(string p, int gray, int bin, bit amax,
                            bit amin, bit bnd, int maxv, int cnt,
                            bit eb, int prev, bit stepped);
        int eg = cnt ^ (cnt >> 1);
        chk({p, "_gray"}, gray, eg);
        chk({p, "_bin"}, bin, cnt);
        chk({p, "_at_max"}, 32'(amax), 32'(cnt == maxv));
        chk({p, "_at_min"}, 32'(amin), 32'(cnt == 0));
        chk({p, "_boundary"}, 32'(bnd), 32'(eb));
        chk({p, "_inv"}, g2b(gray), bin);
        if (stepped && prev != cnt)
            chk({p, "_onebit"}, $countones(eg ^ (prev ^ (prev >> 1))), 1);
    endtask

    task automatic step(bit r, bit e, bit i, bit d, bit l, logic [3:0] v);
        int p4w = m_w4, p4s = m_s4, p1 = m_w1;
        bit st = !r && !l;
        rst = r; en = e; inc = i; dec = d; ld = l; lv = v;
        @(posedge clk);
        #1;
        m_w4 = nxt(m_w4, 15, 1'b0, r, e, i, d, l, int'(v), b_w4);
        m_s4 = nxt(m_s4, 15, 1'b1, r, e, i, d, l, int'(v), b_s4);
        m_w1 = nxt(m_w1, 1, 1'b0, r, e, i, d, l, int'(v[0]), b_w1);
        chk_inst("w4", int'(w4_gray), int'(w4_bin), w4_max, w4_min,
                 w4_bnd, 15, m_w4, b_w4, p4w, st);
        chk_inst("s4", int'(s4_gray), int'(s4_bin), s4_max, s4_min,
                 s4_bnd, 15, m_s4, b_s4, p4s, st);
        chk_inst("w1", int'(w1_gray), int'(w1_bin), w1_max, w1_min,
                 w1_bnd, 1, m_w1, b_w1, p1, st);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; inc = 1'b0; dec = 1'b0; ld = 1'b0; lv = '0;
        step(1, 0, 0, 0, 0, 4'd0);
        step(1, 0, 0, 0, 0, 4'd0);
        // reset mid-count with a simultaneous load
        step(0, 1, 1, 0, 0, 4'd0);
        step(0, 1, 1, 0, 0, 4'd0);
        step(1, 1, 1, 0, 1, 4'd9);
        chk("mid_reset_bin", 32'(w4_bin), 32'd0);
        // full wrap upward
        for (int k = 0; k < 16; k++) step(0, 1, 1, 0, 0, 4'd0);
        chk("wrap_up_gray", 32'(w4_gray), 32'b0000);
        chk("wrap_up_bnd", 32'(w4_bnd), 32'd1);
        step(0, 1, 0, 0, 0, 4'd0);
        chk("bnd_one_cycle", 32'(w4_bnd), 32'd0);
        // wrap downward from zero
        step(1, 0, 0, 0, 0, 4'd0);
        step(0, 1, 0, 1, 0, 4'd0);
        chk("wrap_dn_gray", 32'(w4_gray), 32'b1000);
        chk("sat_dn_hold", 32'(s4_bin), 32'd0);
        step(0, 1, 0, 1, 0, 4'd0);
        chk("dn14_gray", 32'(w4_gray), 32'b1001);
        // saturation at the top
        step(0, 1, 0, 0, 1, 4'd14);
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 4'd0);
        chk("sat_top_gray", 32'(s4_gray), 32'b1000);
        // priority and hold cases
        step(0, 1, 1, 0, 1, 4'd5);
        chk("load_pri_gray", 32'(w4_gray), 32'b0111);
        step(0, 1, 1, 1, 0, 4'd0);
        step(0, 0, 1, 0, 0, 4'd0);
        step(0, 0, 0, 0, 1, 4'd10);
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0,
                 4'($urandom));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
